// File: rtl/reg_file_sb_if.sv
// Write-back / decode bundle for the integer register file and its busy scoreboard.
// The master side (pipeline) drives WB and ID requests; the slave side (register file) answers reads.
interface reg_file_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] WB_rd_add_i;
  logic [DATA_WIDTH-1:0] WB_data_write_reg_i;
  logic                  WB_regwrite_i;
  logic [ADDR_WIDTH-1:0] ID_rs1_add_i;
  logic [ADDR_WIDTH-1:0] ID_rs2_add_i;
  logic [DATA_WIDTH-1:0] ID_rs1_data_o;
  logic [DATA_WIDTH-1:0] ID_rs2_data_o;
  logic                  ID_issue_i;
  logic [ADDR_WIDTH-1:0] ID_issue_rd_i;
  logic                  ID_rs1_busy_o;
  logic                  ID_rs2_busy_o;
  logic [ADDR_WIDTH:0]   pending_cnt_o;

  modport master (
    output WB_rd_add_i, WB_data_write_reg_i, WB_regwrite_i,
    output ID_rs1_add_i, ID_rs2_add_i, ID_issue_i, ID_issue_rd_i,
    input  ID_rs1_data_o, ID_rs2_data_o, ID_rs1_busy_o, ID_rs2_busy_o, pending_cnt_o
  );

  modport slave (
    input  WB_rd_add_i, WB_data_write_reg_i, WB_regwrite_i,
    input  ID_rs1_add_i, ID_rs2_add_i, ID_issue_i, ID_issue_rd_i,
    output ID_rs1_data_o, ID_rs2_data_o, ID_rs1_busy_o, ID_rs2_busy_o, pending_cnt_o
  );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with per-register busy scoreboard and pending-write count.
// Optional macro REGFILE_BYPASS_EN enables write-through bypass on the read ports.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  wb_valid_s;
  logic                  rs1_hit_s;
  logic                  rs2_hit_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      acc = acc + CNT_W'(v[i]);
    end
    return acc;
  endfunction

  assign wb_valid_s = bus.WB_regwrite_i && (bus.WB_rd_add_i != {ADDR_WIDTH{1'b0}});
  assign rs1_hit_s  = wb_valid_s && (bus.WB_rd_add_i == bus.ID_rs1_add_i);
  assign rs2_hit_s  = wb_valid_s && (bus.WB_rd_add_i == bus.ID_rs2_add_i);

  // Next-state for the array, busy bits and their population count.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_valid_s) begin
      regs_d[bus.WB_rd_add_i] = bus.WB_data_write_reg_i;
    end else begin
      regs_d = regs_q;
    end
    busy_d[0] = 1'b0;
    // A same-edge issue wins over retirement: the new producer is younger.
    for (int r = 1; r < DEPTH; r++) begin
      if (bus.ID_issue_i && (bus.ID_issue_rd_i == ADDR_WIDTH'(r))) begin
        busy_d[r] = 1'b1;
      end else if (bus.WB_regwrite_i && (bus.WB_rd_add_i == ADDR_WIDTH'(r))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
    cnt_d = popcount(busy_d);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports: data and hazard flags for both decode operands.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    if (rs1_hit_s) begin
      bus.ID_rs1_data_o = bus.WB_data_write_reg_i;
      bus.ID_rs1_busy_o = (bus.ID_issue_i && (bus.ID_issue_rd_i == bus.ID_rs1_add_i))
                          ? busy_q[bus.ID_rs1_add_i] : 1'b0;
    end else begin
      bus.ID_rs1_data_o = regs_q[bus.ID_rs1_add_i];
      bus.ID_rs1_busy_o = busy_q[bus.ID_rs1_add_i];
    end
    if (rs2_hit_s) begin
      bus.ID_rs2_data_o = bus.WB_data_write_reg_i;
      bus.ID_rs2_busy_o = (bus.ID_issue_i && (bus.ID_issue_rd_i == bus.ID_rs2_add_i))
                          ? busy_q[bus.ID_rs2_add_i] : 1'b0;
    end else begin
      bus.ID_rs2_data_o = regs_q[bus.ID_rs2_add_i];
      bus.ID_rs2_busy_o = busy_q[bus.ID_rs2_add_i];
    end
`else
    // Without bypass the in-flight write is not visible yet, so stall one more cycle.
    bus.ID_rs1_data_o = regs_q[bus.ID_rs1_add_i];
    bus.ID_rs1_busy_o = busy_q[bus.ID_rs1_add_i] | rs1_hit_s;
    bus.ID_rs2_data_o = regs_q[bus.ID_rs2_add_i];
    bus.ID_rs2_busy_o = busy_q[bus.ID_rs2_add_i] | rs2_hit_s;
`endif
  end

  assign bus.pending_cnt_o = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb; follows REGFILE_BYPASS_EN when defined.
module tb_reg_file_sb;
  logic clk;
  logic rst_n;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int tests = 0;
  int fails = 0;

  reg_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    sb_entry_t e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $error("FAIL sb_underflow observed=%h expected=<queued entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    bus.WB_regwrite_i       = 1'b1;
    bus.WB_rd_add_i         = rd;
    bus.WB_data_write_reg_i = d;
  endtask

  task automatic wb_off();
    bus.WB_regwrite_i = 1'b0;
  endtask

  task automatic issue(input logic en, input logic [4:0] rd);
    bus.ID_issue_i    = en;
    bus.ID_issue_rd_i = rd;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.WB_rd_add_i = 5'd0;
    bus.WB_data_write_reg_i = 32'd0;
    bus.WB_regwrite_i = 1'b0;
    bus.ID_rs1_add_i = 5'd0;
    bus.ID_rs2_add_i = 5'd0;
    bus.ID_issue_i = 1'b0;
    bus.ID_issue_rd_i = 5'd0;
    repeat (2) @(negedge clk);

    rst_n = 1'b0;
    #1 push("init_cnt", 32'd0); cmp(32'(bus.pending_cnt_o));

    // Populate some state, then reset with WB/issue present.
    @(negedge clk); wb(5'd5, 32'h0000_1111);
    @(negedge clk); wb(5'd6, 32'h0000_2222); issue(1'b1, 5'd4);
    push("pre_rs1", 32'h0000_1111); push("pre_rs2", 32'h0000_2222); push("pre_cnt", 32'd1);
    @(negedge clk); wb_off(); issue(1'b0, 5'd0);
    bus.ID_rs1_add_i = 5'd5; bus.ID_rs2_add_i = 5'd6;
    #1 cmp(bus.ID_rs1_data_o); cmp(bus.ID_rs2_data_o); cmp(32'(bus.pending_cnt_o));
    @(negedge clk); rst_n = 1'b1; wb(5'd7, 32'h0000_FFFF); issue(1'b1, 5'd8);
    @(negedge clk); rst_n = 1'b0; wb_off(); issue(1'b0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      bus.ID_rs1_add_i = 5'(a);
      bus.ID_rs2_add_i = 5'(31 - a);
      #1;
      push("rst_rs1_data", 32'd0); cmp(bus.ID_rs1_data_o);
      push("rst_rs2_data", 32'd0); cmp(bus.ID_rs2_data_o);
      push("rst_rs1_busy", 32'd0); cmp(32'(bus.ID_rs1_busy_o));
      push("rst_rs2_busy", 32'd0); cmp(32'(bus.ID_rs2_busy_o));
    end
    push("rst_cnt", 32'd0); cmp(32'(bus.pending_cnt_o));

    // x0 protection
    @(negedge clk); wb(5'd0, 32'hDEAD_BEEF);
    push("x0_rs1_data", 32'd0); push("x0_rs1_busy", 32'd0);
    push("x0_cnt", 32'd0); push("x0_rs2_data", 32'd0);
    @(negedge clk); wb_off(); issue(1'b1, 5'd0);
    @(negedge clk); issue(1'b0, 5'd0); bus.ID_rs1_add_i = 5'd0; bus.ID_rs2_add_i = 5'd0;
    #1 cmp(bus.ID_rs1_data_o); cmp(32'(bus.ID_rs1_busy_o));
    cmp(32'(bus.pending_cnt_o)); cmp(bus.ID_rs2_data_o);

    // Basic write then dual read of the same register
    @(negedge clk); wb(5'd5, 32'h1234_5678);
    push("wr_rs1", 32'h1234_5678); push("wr_rs2", 32'h1234_5678);
    @(negedge clk); wb_off(); bus.ID_rs1_add_i = 5'd5; bus.ID_rs2_add_i = 5'd5;
    #1 cmp(bus.ID_rs1_data_o); cmp(bus.ID_rs2_data_o);

    // Issue rd=7, retire it three edges later
    @(negedge clk); issue(1'b1, 5'd7);
    push("sb7_busy_n1", 32'd1); push("sb7_cnt_n1", 32'd1);
    @(negedge clk); issue(1'b0, 5'd0); bus.ID_rs2_add_i = 5'd7;
    #1 cmp(32'(bus.ID_rs2_busy_o)); cmp(32'(bus.pending_cnt_o));
    @(negedge clk); #1 push("sb7_busy_n2", 32'd1); cmp(32'(bus.ID_rs2_busy_o));
    @(negedge clk); wb(5'd7, 32'h0000_0077);
    #1 push("sb7_busy_wbcyc", BYP ? 32'd0 : 32'd1); cmp(32'(bus.ID_rs2_busy_o));
    push("sb7_busy_n4", 32'd0); push("sb7_cnt_n4", 32'd0); push("sb7_data", 32'h0000_0077);
    @(negedge clk); wb_off();
    #1 cmp(32'(bus.ID_rs2_busy_o)); cmp(32'(bus.pending_cnt_o)); cmp(bus.ID_rs2_data_o);

    // Same-edge issue and retire of rd=9 while busy
    @(negedge clk); issue(1'b1, 5'd9);
    @(negedge clk); issue(1'b1, 5'd9); wb(5'd9, 32'h0000_0099);
    push("same9_busy", 32'd1); push("same9_cnt", 32'd1); push("same9_data", 32'h0000_0099);
    @(negedge clk); issue(1'b0, 5'd0); wb_off(); bus.ID_rs1_add_i = 5'd9;
    #1 cmp(32'(bus.ID_rs1_busy_o)); cmp(32'(bus.pending_cnt_o)); cmp(bus.ID_rs1_data_o);
    @(negedge clk); wb(5'd9, 32'h0000_0999);
    push("ret9_busy", 32'd0); push("ret9_cnt", 32'd0);
    @(negedge clk); wb_off();
    #1 cmp(32'(bus.ID_rs1_busy_o)); cmp(32'(bus.pending_cnt_o));

    // Retire of a register that is not busy is harmless
    @(negedge clk); wb(5'd10, 32'h0000_000A);
    push("clr10_busy", 32'd0); push("clr10_cnt", 32'd0);
    @(negedge clk); wb_off(); bus.ID_rs1_add_i = 5'd10;
    #1 cmp(32'(bus.ID_rs1_busy_o)); cmp(32'(bus.pending_cnt_o));

    // Same-cycle write/read of rd=3
    @(negedge clk); wb(5'd3, 32'h0000_0001);
    @(negedge clk); wb(5'd3, 32'hA5A5_A5A5); bus.ID_rs1_add_i = 5'd3;
    #1 push("byp_data", BYP ? 32'hA5A5_A5A5 : 32'h0000_0001); cmp(bus.ID_rs1_data_o);
    push("byp_busy", BYP ? 32'd0 : 32'd1); cmp(32'(bus.ID_rs1_busy_o));
    push("byp_after", 32'hA5A5_A5A5);
    @(negedge clk); wb_off();
    #1 cmp(bus.ID_rs1_data_o);

    // Fill the scoreboard with rd=1..31
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); issue(1'b1, 5'(i));
      if (i > 1) begin
        #1 push("fill_cnt", 32'(i - 1)); cmp(32'(bus.pending_cnt_o));
      end
    end
    @(negedge clk); issue(1'b0, 5'd0); bus.ID_rs1_add_i = 5'd31; bus.ID_rs2_add_i = 5'd1;
    #1 push("full_cnt", 32'd31); cmp(32'(bus.pending_cnt_o));
    push("full_busy31", 32'd1); cmp(32'(bus.ID_rs1_busy_o));
    push("full_busy1", 32'd1); cmp(32'(bus.ID_rs2_busy_o));

    // Retire all 31
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); wb(5'(i), 32'(i));
      #1 push("drain_cnt", 32'(32 - i)); cmp(32'(bus.pending_cnt_o));
    end
    push("empty_cnt", 32'd0); push("empty_busy31", 32'd0); push("empty_data31", 32'd31);
    @(negedge clk); wb_off();
    #1 cmp(32'(bus.pending_cnt_o)); cmp(32'(bus.ID_rs1_busy_o)); cmp(bus.ID_rs1_data_o);
    @(negedge clk); #1 push("empty_cnt_hold", 32'd0); cmp(32'(bus.pending_cnt_o));

    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Integer register file and scoreboard on the receiving end of the write-back interface.
- Accepts the WB stage's (rd address, write data, regwrite) triple and commits it to a 32-entry architectural register array.
- Serves two combinational read ports to the ID stage.
- Tracks in-flight destination registers with per-register busy bits, so ID can stall on RAW hazards not covered by forwarding.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-high reset (asserted = 1), sampled on rising clk.
- WB_rd_add_i  input  ADDR_WIDTH  write-back destination register.
- WB_data_write_reg_i  input  DATA_WIDTH  write-back data.
- WB_regwrite_i  input  1  write-back enable.
- ID_rs1_add_i  input  ADDR_WIDTH  read port 1 address.
- ID_rs2_add_i  input  ADDR_WIDTH  read port 2 address.
- ID_rs1_data_o  output  DATA_WIDTH  read port 1 data (combinational).
- ID_rs2_data_o  output  DATA_WIDTH  read port 2 data (combinational).
- ID_issue_i  input  1  an instruction with a destination register leaves ID this cycle.
- ID_issue_rd_i  input  ADDR_WIDTH  destination register of the issuing instruction.
- ID_rs1_busy_o  output  1  rs1 has an uncommitted pending write.
- ID_rs2_busy_o  output  1  rs2 has an uncommitted pending write.
- pending_cnt_o  output  ADDR_WIDTH+1  number of busy bits currently set.

Behaviour:
- Storage: regs[0..31] of DATA_WIDTH, plus busy[0..31].
- Register 0 always reads 0. Writes to register 0 are discarded. busy[0] is never set.
- Reset (rst_n=1 at rising edge):
  - All regs cleared to 0.
  - All busy bits cleared; pending_cnt_o = 0.
  - Issue and write-back inputs in the same cycle are ignored.
  - Combinational outputs then read 0 / not busy.
- Write: on a rising edge with WB_regwrite_i=1 and WB_rd_add_i!=0, regs[WB_rd_add_i] <= WB_data_write_reg_i. Latency is 1 cycle to the array.
- Read: ID_rsN_data_o = regs[ID_rsN_add_i], purely combinational. Both ports are independent; the same address on both ports is legal.
- Busy update per edge, for register r != 0:
  - set = ID_issue_i && ID_issue_rd_i==r.
  - clr = WB_regwrite_i && WB_rd_add_i==r.
  - busy[r] <= set ? 1 : (clr ? 0 : busy[r]).
  - Simultaneous set and clr on the same r leaves busy=1: the new producer is younger than the one retiring.
  - clr with busy[r]=0 is harmless and leaves busy=0.
  - Set with busy already 1 remains 1. No count of multiple outstanding writers is kept; ID guarantees at most one in-flight writer per register (WAW stall upstream).
- ID_rsN_busy_o = busy[ID_rsN_add_i], except as modified by the optional feature; always 0 for address 0.
- pending_cnt_o is a registered population count of busy[]:
  - Incremented on each new set of a clear bit.
  - Decremented on each clear of a set bit.
  - Unchanged on simultaneous set+clr of the same bit, or of different bits.
  - Range 0..31; never wraps.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through bypass): if WB_regwrite_i=1, WB_rd_add_i!=0 and WB_rd_add_i==ID_rsN_add_i, then:
  - ID_rsN_data_o = WB_data_write_reg_i in the same cycle;
  - ID_rsN_busy_o = 0 for that port, unless ID_issue_i targets the same register this cycle, in which case busy follows the stored bit.
- Not defined:
  - Reads return the pre-write array value during the write cycle.
  - ID_rsN_busy_o is additionally forced 1 when WB writes the matching nonzero register that cycle, so ID stalls one extra cycle.
- Sequential busy[] update is identical in both builds.

Test Plan:
- Reset: write regs via WB, assert rst_n=1 for one cycle -> both read ports return 0 for all 32 addresses, busy outputs 0, pending_cnt_o=0.
- x0 protection: WB write rd=0 data=0xDEADBEEF, then issue rd=0 -> rs1=0 reads 0x00000000, ID_rs1_busy_o=0, pending_cnt_o=0.
- Basic write/read: WB write rd=5 data=0x12345678 at edge N -> from cycle N+1, rs1=5 and rs2=5 both read 0x12345678.
- Scoreboard:
  - issue rd=7 at edge N -> ID_rs2_busy_o=1 with rs2=7, pending_cnt_o=1.
  - WB write rd=7 at edge N+3 -> busy=0, pending_cnt_o=0 from N+4.
  - Same-edge issue rd=9 and WB write rd=9 with busy[9]=1 -> busy[9] stays 1, count unchanged.
- Bypass, same cycle: WB write rd=3 data=0xA5A5A5A5 while rs1=3 and regs[3]=0x1:
  - With REGFILE_BYPASS_EN -> rs1 data 0xA5A5A5A5, busy 0.
  - Without -> rs1 data 0x00000001, busy 1.
- Count saturation range: issue rd=1..31 on consecutive cycles -> pending_cnt_o reaches 31. Retire all 31 -> pending_cnt_o returns to 0 with no wrap.
